uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
// - UART receiver for the Uart_RX pin (8N1, LSB first); receive-side counterpart of uart_tx, same baud parameters.
// - Synchronises the async line, samples each bit at its midpoint, checks the stop bit, buffers bytes in a small FIFO.
// - Presents bytes to a consumer with a valid/ready handshake, e.g. an echo loop into uart_tx or a command parser.
// PARAMETERS
// - CLOCK_FREQUENCY  27000000  system clock in Hz
// - BAUD_RATE        115200    line rate in bit/s
// - BAUD_DIVISOR     CLOCK_FREQUENCY/BAUD_RATE (234)  clocks per bit, integer-truncated
// - FIFO_DEPTH       4         receive FIFO entries; power of 2, >=2
// PORTS
// - clk          in   1  system clock
// - rst          in   1  reset, asynchronous, active-high
// - rx           in   1  serial input, idle high, asynchronous to clk
// - rx_data      out  8  FIFO head byte; valid only while rx_valid=1
// - rx_valid     out  1  FIFO not empty
// - rx_ready     in   1  consumer accepts head byte when rx_valid&&rx_ready
// - frame_error  out  1  one-cycle pulse: stop bit sampled 0
// - overrun      out  1  one-cycle pulse: good byte dropped, FIFO full
// BEHAVIOUR
// - One clock (clk); reset is asynchronous and active-high (rst). Reset: rx_data=0, rx_valid=0, frame_error=0,
//   overrun=0; FIFO empty; 2-FF synchroniser regs=1; bit counter=0; state=WAIT_IDLE.
// - Synchroniser: rx -> 2 flops -> rx_s; all decisions use rx_s only (2-cycle input latency).
// - FSM: WAIT_IDLE: stay until rx_s=1, then IDLE (prevents arming mid-frame after reset or framing error).
//   IDLE: rx_s=0 -> START, baud counter cleared.
//   START: at count BAUD_DIVISOR/2-1 sample rx_s; 0 -> DATA (counter cleared, bit index 0); 1 -> IDLE (glitch reject).
//   DATA: every BAUD_DIVISOR clocks sample rx_s into shift reg bit[index], LSB first; after index 7 -> STOP.
//   STOP: after BAUD_DIVISOR clocks sample rx_s; 1 -> push byte, IDLE; 0 -> frame_error pulse, byte discarded, WAIT_IDLE.
// - Baud counter width $clog2(BAUD_DIVISOR); counts 0..BAUD_DIVISOR-1, wraps to 0 at each sample point.
// - FIFO is first-word-fall-through: byte pushed on cycle N -> rx_valid=1, rx_data=byte on cycle N+1 if FIFO was empty.
// - Pop when rx_valid&&rx_ready; next entry (or rx_valid=0) visible the following cycle.
// - Full and push: if pop in same cycle, push accepted, count unchanged; else byte dropped, overrun pulses 1 cycle.
// - Empty and pop: impossible (rx_valid=0); rx_ready ignored while empty.
// - Pointers log2(FIFO_DEPTH) bits, wrap naturally; count log2(FIFO_DEPTH)+1 bits, 0..FIFO_DEPTH.
// - rx_data holds last head value when empty (no X); consumer must qualify with rx_valid.
// - Reset mid-frame: all state discarded, partial byte lost, FIFO flushed; re-arms only after rx_s=1 seen.
// - frame_error and overrun never assert in the same cycle (mutually exclusive STOP outcomes).
// STRUCTURE
// - Shared package/include: baud parameter defaults (CLOCK_FREQUENCY, BAUD_RATE, derived BAUD_DIVISOR) used by uart_tx
//   and uart_rx; FSM state encoding localparams (WAIT_IDLE, IDLE, START, DATA, STOP) local to this file.
// - One sub-module: uart_rx_fifo (sync FWFT FIFO, params WIDTH=8, DEPTH; ports clk, rst, push, push_data, pop,
//   pop_data, empty, full). Synchroniser, baud counter and FSM live in uart_rx.
// TESTING
// - Bench sends frames at exact BAUD_DIVISOR=234 clocks/bit; rx_ready held 1 unless stated.
// - Send 0x55 then 0xA3 -> rx_valid pulses twice, rx_data 0x55 then 0xA3; first valid <=BAUD_DIVISOR/2+4 clocks after stop-bit start.
// - rx low for 50 clocks only, then high -> FSM returns IDLE, no rx_valid, no frame_error.
// - Send 0x3C with stop bit 0, line held low 1000 clocks, then 0x7E -> frame_error 1 pulse, 0x3C absent, 0x7E received.
// - rx_ready=0, send 5 bytes 0x01..0x05 (DEPTH 4) -> overrun 1 pulse on 5th; then rx_ready=1 drains 0x01..0x04 in order.
// - Full FIFO, rx_ready pulsed 1 exactly on the 5th byte's push cycle -> no overrun, 0x02..0x05 drained.
// - Assert rst during bit 4 of a frame with rx held low -> outputs 0, no byte; after rx high, next 0xC5 received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART baud defaults, used by both uart_tx and uart_rx.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_rx_pkg;

  localparam int unsigned DEFAULT_CLOCK_FREQUENCY = 27_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE       = 115_200;
  localparam int unsigned DEFAULT_FIFO_DEPTH      = 4;

  // Clocks per bit, integer-truncated (234 at the defaults).
  function automatic int unsigned baud_divisor(input int unsigned clock_hz, input int unsigned baud);
    return clock_hz / baud;
  endfunction

  localparam int unsigned DEFAULT_BAUD_DIVISOR =
    baud_divisor(DEFAULT_CLOCK_FREQUENCY, DEFAULT_BAUD_RATE);

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous first-word-fall-through FIFO for received bytes.
// Latency: a byte pushed into an empty FIFO appears on pop_data the next cycle.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
// Ports: clk, rst (async, active-high), push/push_data, pop/pop_data, empty, full.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] last_head;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot being written, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  // While empty, keep showing the last head byte rather than a stale memory slot.
  assign pop_data = empty ? last_head : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_head <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, mid-bit sampling FSM, byte FIFO with valid/ready output.
// Latency: 2 cycles sync; byte visible ~BAUD_DIVISOR/2+3 clocks after the stop bit begins.
// Backpressure: rx_ready low lets the FIFO fill; a good byte arriving while full is dropped with an overrun pulse.
// Ports: clk, rst (async, active-high), rx (async serial in), rx_data/rx_valid/rx_ready, frame_error, overrun.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int unsigned BAUD_RATE       = DEFAULT_BAUD_RATE,
  parameter int unsigned BAUD_DIVISOR    = CLOCK_FREQUENCY / BAUD_RATE,
  parameter int unsigned FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIVISOR);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIVISOR - 1);

  localparam logic [2:0] WAIT_IDLE = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;

  logic             rx_meta;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             sample;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;

  // Start bit is checked at its midpoint; all later bits are a full bit period apart.
  assign sample   = (state == START) ? (baud_cnt == HALF_CNT) : (baud_cnt == LAST_CNT);
  assign push     = (state == STOP) && sample && rx_s;
  assign rx_valid = !fifo_empty;
  assign pop      = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      // Stop bit 1 (push) and stop bit 0 (frame_error) are exclusive, so the pulses never overlap.
      overrun     <= push && fifo_full && !pop;
      case (state)
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (sample) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (sample) begin
            baud_cnt       <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (sample) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift),
    .pop       (pop),
    .pop_data  (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
